// File: rtl/imem_sync_loader_pkg.sv
// Shared types and default constants for the loadable instruction memory.
package imem_pkg;

  // Lifecycle of the memory: wipe to NOP, accept a program, then serve fetches.
  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } imem_state_t;

  localparam int          IMEM_DATA_W      = 16;
  localparam int          IMEM_ADDR_W      = 10;
  localparam int          IMEM_DEPTH       = 1000;
  localparam logic [15:0] NOP_WORD_DEFAULT = 16'h8040;

endpackage : imem_pkg

// File: rtl/imem_sync_loader_if.sv
// Loader write port and CPU fetch port of the instruction memory, bundled.
interface imem_sync_loader_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
);

  // loader side
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              load_done;
  logic              load_err;

  // CPU side
  logic              cpu_hold;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_stall;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              addr_fault;

  // Loader/CPU view: drives requests, receives status and instructions.
  modport master (
    output load_en, load_addr, load_data, load_done,
    output fetch_req, fetch_addr, fetch_stall,
    input  load_err, cpu_hold, instr, instr_valid, addr_fault
  );

  // Memory view.
  modport slave (
    input  load_en, load_addr, load_data, load_done,
    input  fetch_req, fetch_addr, fetch_stall,
    output load_err, cpu_hold, instr, instr_valid, addr_fault
  );

endinterface : imem_sync_loader_if

// File: rtl/imem_sync_loader_array.sv
// Plain storage: one synchronous write port, one synchronous read port with
// enable so the read register holds its word between accepted fetches.
// No reset on the storage or read register so it maps onto block RAM.
module imem_array #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1000
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // write port: callers guarantee wr_addr < DEPTH
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // registered read port: callers guarantee rd_addr < DEPTH when rd_en
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule : imem_array

// File: rtl/imem_sync_loader.sv
// Loadable instruction memory: clears itself to NOP after reset, accepts a
// program through the loader port, then serves 1-cycle-latency fetches.
module imem_sync_loader
  import imem_pkg::*;
#(
  parameter int                DATA_W   = IMEM_DATA_W,
  parameter int                ADDR_W   = IMEM_ADDR_W,
  parameter int                DEPTH    = IMEM_DEPTH,
  parameter logic [DATA_W-1:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  imem_sync_loader_if.slave  bus
);

  localparam int                CNT_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0]  CLR_LAST = CNT_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_A  = (ADDR_W + 1)'(DEPTH);

  imem_state_t       state_reg, state_next;
  logic [CNT_W-1:0]  clr_cnt_reg, clr_cnt_next;
  logic              load_err_reg, load_err_next;
  logic              instr_valid_reg;
  logic              addr_fault_reg;
  logic              nop_sel_reg;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              load_in_range;
  logic              fetch_in_range;
  logic              fetch_take;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;

  assign load_in_range  = ({1'b0, bus.load_addr}  < DEPTH_A);
  assign fetch_in_range = ({1'b0, bus.fetch_addr} < DEPTH_A);

  // a fetch is taken only in RUN and only when the CPU is not stalling
  assign fetch_take = (state_reg == RUN) && bus.fetch_req && !bus.fetch_stall;
  // out-of-range fetches never touch the array; the output mux supplies NOP
  assign rd_en      = fetch_take && fetch_in_range;

  // state, clear counter and reject pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= CLEAR;
      clr_cnt_reg  <= '0;
      load_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      clr_cnt_reg  <= clr_cnt_next;
      load_err_reg <= load_err_next;
    end
  end

  // next state, write mux (clear sweep vs loader) and loader rejection
  always_comb begin
    state_next    = state_reg;
    clr_cnt_next  = clr_cnt_reg;
    load_err_next = 1'b0;
    wr_en         = 1'b0;
    wr_addr       = '0;
    wr_data       = '0;
    unique case (state_reg)
      CLEAR: begin
        wr_en         = 1'b1;
        wr_addr       = ADDR_W'(clr_cnt_reg);
        wr_data       = NOP_WORD;
        load_err_next = bus.load_en;
        // counter stops at the last word rather than wrapping
        if (clr_cnt_reg == CLR_LAST) begin
          state_next = LOAD;
        end else begin
          clr_cnt_next = clr_cnt_reg + 1'b1;
        end
      end
      LOAD: begin
        if (bus.load_en) begin
          if (load_in_range) begin
            wr_en   = 1'b1;
            wr_addr = bus.load_addr;
            wr_data = bus.load_data;
          end else begin
            load_err_next = 1'b1;
          end
        end
        // a write on the same edge as load_done still lands
        if (bus.load_done) begin
          state_next = RUN;
        end
      end
      RUN: begin
        load_err_next = bus.load_en;
      end
      default: begin
        state_next = CLEAR;
      end
    endcase
  end

  // fetch result flags; everything holds while stalled or outside RUN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_valid_reg <= 1'b0;
      addr_fault_reg  <= 1'b0;
      nop_sel_reg     <= 1'b1;
    end else if ((state_reg == RUN) && !bus.fetch_stall) begin
      instr_valid_reg <= bus.fetch_req;
      if (bus.fetch_req) begin
        addr_fault_reg <= !fetch_in_range;
        nop_sel_reg    <= !fetch_in_range;
      end
    end
  end

  imem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (bus.fetch_addr),
    .rd_data (rd_data)
  );

  // nop_sel covers both reset (array read register is not reset) and faults
  assign bus.instr       = nop_sel_reg ? NOP_WORD : rd_data;
  assign bus.instr_valid = instr_valid_reg;
  assign bus.addr_fault  = addr_fault_reg;
  assign bus.load_err    = load_err_reg;
  assign bus.cpu_hold    = (state_reg != RUN);

endmodule : imem_sync_loader

// File: tb/tb_imem_sync_loader.sv
// Randomized bench for imem_sync_loader against a cycle-count/array model.
module tb_imem_sync_loader;

  localparam int          DEPTH = 1000;
  localparam logic [15:0] NOP   = 16'h8040;

  logic clk;
  logic rst;

  imem_sync_loader_if #(.DATA_W(16), .ADDR_W(10)) bus ();

  imem_sync_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // reference: memory image, edges since reset, and whether load_done was taken
  logic [15:0] ref_mem [DEPTH];
  int          since_rst;
  bit          done_seen;
  logic [15:0] exp_instr;
  bit          exp_valid;
  bit          exp_fault;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = NOP;
    since_rst = 0;
    done_seen = 0;
    exp_instr = NOP;
    exp_valid = 0;
    exp_fault = 0;
  endtask

  task automatic drive_idle();
    bus.load_en     = 0;
    bus.load_addr   = '0;
    bus.load_data   = '0;
    bus.load_done   = 0;
    bus.fetch_req   = 0;
    bus.fetch_addr  = '0;
    bus.fetch_stall = 0;
  endtask

  // one clock: drive, predict, clock, check
  task automatic tick(input bit le, input int la, input logic [15:0] ld, input bit ldone,
                      input bit fr, input int fa, input bit fs);
    bit in_clear;
    bit in_run;
    bit in_load;
    bit exp_err;
    in_clear = (since_rst < DEPTH);
    in_run   = !in_clear && done_seen;
    in_load  = !in_clear && !in_run;

    bus.load_en     = le;
    bus.load_addr   = 10'(la);
    bus.load_data   = ld;
    bus.load_done   = ldone;
    bus.fetch_req   = fr;
    bus.fetch_addr  = 10'(fa);
    bus.fetch_stall = fs;

    exp_err = le && (!in_load || la >= DEPTH);
    if (in_load && le && la < DEPTH) ref_mem[la] = ld;
    if (in_run && !fs) begin
      exp_valid = fr;
      if (fr) begin
        exp_fault = (fa >= DEPTH);
        exp_instr = (fa >= DEPTH) ? NOP : ref_mem[fa];
      end
    end
    if (in_load && ldone) done_seen = 1;
    since_rst++;

    @(posedge clk);
    #1;
    check_eq("load_err",    32'(bus.load_err),    32'(exp_err));
    check_eq("instr",       32'(bus.instr),       32'(exp_instr));
    check_eq("instr_valid", 32'(bus.instr_valid), 32'(exp_valid));
    check_eq("addr_fault",  32'(bus.addr_fault),  32'(exp_fault));
    check_eq("cpu_hold",    32'(bus.cpu_hold),    32'(!done_seen));
    if (le || fr)
      $display("cyc=%0d le=%0b la=%0d ld=%h done=%0b fr=%0b fa=%0d fs=%0b -> err=%0b instr=%h v=%0b f=%0b hold=%0b",
               since_rst, le, la, ld, ldone, fr, fa, fs, bus.load_err, bus.instr,
               bus.instr_valid, bus.addr_fault, bus.cpu_hold);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 16'h0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    drive_idle();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_eq("rst_instr",       32'(bus.instr),       32'(NOP));
    check_eq("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    check_eq("rst_addr_fault",  32'(bus.addr_fault),  32'd0);
    check_eq("rst_load_err",    32'(bus.load_err),    32'd0);
    check_eq("rst_cpu_hold",    32'(bus.cpu_hold),    32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    $display("reset released t=%0t", $time);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    drive_idle();
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // CLEAR: load attempt rejected, fetch ignored, then reset at cycle 500
    idle(10);
    tick(1, 5, 16'h1234, 0, 1, 3, 0);
    idle(489);
    tick(0, 0, 16'h0, 1, 0, 0, 0);  // load_done in CLEAR must be ignored
    do_reset();

    // full clear again: last CLEAR cycle still rejects, first LOAD cycle accepts
    idle(999);
    tick(1, 3, 16'hDEAD, 0, 0, 0, 0);
    check_eq("clear_last_err", 32'(bus.load_err), 32'd1);
    tick(1, 0, 16'h8080, 0, 0, 0, 0);
    check_eq("load_first_ok", 32'(bus.load_err), 32'd0);
    tick(1, 1000, 16'hBEEF, 0, 0, 0, 0);
    tick(1, 2, 16'h05F4, 0, 0, 0, 0);
    tick(1, 1023, 16'hBEEF, 0, 0, 0, 0);
    for (int i = 0; i < 60; i++)
      tick($urandom_range(0, 1), $urandom_range(10, 1023), 16'($urandom), 0, 0, 0, 0);
    tick(1, 9, 16'h4A5A, 1, 0, 0, 0);  // write and load_done together
    check_eq("run_hold_low", 32'(bus.cpu_hold), 32'd0);

    // RUN: directed fetches
    tick(0, 0, 16'h0, 0, 1, 7, 0);
    check_eq("fetch7_nop", 32'(bus.instr), 32'(NOP));
    tick(0, 0, 16'h0, 0, 1, 0, 0);
    check_eq("fetch0_val", 32'(bus.instr), 32'h8080);
    tick(0, 0, 16'h0, 0, 1, 2, 0);
    check_eq("fetch2_val", 32'(bus.instr), 32'h05F4);
    tick(0, 0, 16'h0, 0, 1, 1000, 0);
    tick(0, 0, 16'h0, 0, 1, 999, 0);
    tick(0, 0, 16'h0, 0, 1, 1023, 0);
    tick(0, 0, 16'h0, 0, 0, 0, 0);
    tick(0, 0, 16'h0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 16'h0, 0, 1, 2, 1);
    check_eq("stall_hold", 32'(bus.instr), 32'h8080);
    tick(1, 4, 16'h7777, 1, 1, 9, 0);  // load in RUN rejected
    tick(0, 0, 16'h0, 0, 1, 3, 0);     // CLEAR-time write never landed
    tick(0, 0, 16'h0, 0, 1, 4, 0);     // RUN-time write never landed

    // RUN: randomized traffic
    for (int i = 0; i < 300; i++)
      tick($urandom_range(0, 7) == 0, $urandom_range(0, 1023), 16'($urandom), $urandom_range(0, 1),
           $urandom_range(0, 3) != 0, $urandom_range(0, 1023), $urandom_range(0, 3) == 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_imem_sync_loader
